// File: rtl/game_screen_ctrl.sv
// Screen sequencer for the VGA game: tracks menu/play/winner phases and
// switches the screen mux only on vsync rising edges so frames never tear.
module game_screen_ctrl #(
   parameter int HOLD_FRAMES  = 300,
   parameter int BLINK_FRAMES = 30,
   parameter int CNT_W        = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_btn,
   input  logic       p1_win,
   input  logic       p2_win,
   input  logic       vsync,
   output logic [1:0] screen_sel,
   output logic       game_en,
   output logic       game_rst,
   output logic       blink_on,
   output logic [1:0] state_dbg
);

   // State encodings double as the screen mux select values.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      WIN1 = 2'd2,
      WIN2 = 2'd3
   } state_t;

   localparam int HOLD_EFF = (HOLD_FRAMES < 1) ? 1 : HOLD_FRAMES;
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_EFF - 1);
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   state_t           state_q, state_d;
   logic             vsync_q, start_q;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_on_q, blink_on_d;
   logic [1:0]       screen_sel_q;
   logic             game_en_q, game_rst_q;
   logic             frame_tick, start_rise;
   logic             in_win_q, in_win_d;

   assign frame_tick = vsync & ~vsync_q;
   assign start_rise = start_btn & ~start_q;
   assign in_win_q   = (state_q == WIN1) || (state_q == WIN2);
   assign in_win_d   = (state_d == WIN1) || (state_d == WIN2);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       if (start_rise) state_d = PLAY;
         PLAY: begin
            if (p1_win)      state_d = WIN1;
            else if (p2_win) state_d = WIN2;
         end
         WIN1, WIN2: if (frame_tick && (frame_cnt_q == HOLD_LAST)) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // A transition clears the counters; a tick in the same cycle is not counted.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
      if (state_d != state_q) begin
         frame_cnt_d = '0;
         blink_cnt_d = '0;
         blink_on_d  = in_win_d;
      end else if (in_win_q && frame_tick) begin
         if (frame_cnt_q != CNT_MAX) frame_cnt_d = frame_cnt_q + 1'b1;
         if (blink_cnt_q == BLINK_LAST) begin
            blink_on_d  = ~blink_on_q;
            blink_cnt_d = '0;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end else if (!in_win_q) begin
         blink_on_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         vsync_q      <= 1'b1;
         start_q      <= 1'b0;
         frame_cnt_q  <= '0;
         blink_cnt_q  <= '0;
         blink_on_q   <= 1'b0;
         screen_sel_q <= 2'd0;
         game_en_q    <= 1'b0;
         game_rst_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         vsync_q     <= vsync;
         start_q     <= start_btn;
         frame_cnt_q <= frame_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         game_en_q   <= (state_q == PLAY);
         game_rst_q  <= (state_q == IDLE) && start_rise;
         if (frame_tick) screen_sel_q <= state_q;
      end
   end

   assign screen_sel = screen_sel_q;
   assign game_en    = game_en_q;
   assign game_rst   = game_rst_q;
   assign blink_on   = blink_on_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Bench for game_screen_ctrl: directed vector table, randomized run against
// a phase/frame-count reference model, and hand-written winner-screen sequences.
module tb_game_screen_ctrl;

   localparam int HOLD  = 4;
   localparam int BLINK = 2;

   logic       clk = 1'b0;
   logic       rst, start_btn, p1_win, p2_win, vsync;
   logic [1:0] screen_sel, state_dbg;
   logic       game_en, game_rst, blink_on;

   int checks = 0;
   int errors = 0;

   game_screen_ctrl #(.HOLD_FRAMES(HOLD), .BLINK_FRAMES(BLINK), .CNT_W(10)) dut (
      .clk(clk), .rst(rst), .start_btn(start_btn), .p1_win(p1_win), .p2_win(p2_win),
      .vsync(vsync), .screen_sel(screen_sel), .game_en(game_en), .game_rst(game_rst),
      .blink_on(blink_on), .state_dbg(state_dbg)
   );

   initial forever #5 clk = ~clk;

   // Reference model: phase 0 menu, 1 play, 2/3 winner; n = ticks seen in phase.
   int         m_phase = 0;
   int         m_n = 0;
   bit         m_vs_prev = 1'b1, m_st_prev = 1'b0;
   logic [1:0] m_sel = 2'd0;
   bit         m_en = 0, m_grst = 0, m_blink = 0;

   task automatic model_update(input bit r, input bit s, input bit a, input bit b, input bit v);
      bit tick, rise;
      int nxt;
      if (r) begin
         m_phase = 0; m_n = 0; m_sel = 2'd0; m_en = 0; m_grst = 0; m_blink = 0;
         m_vs_prev = 1'b1; m_st_prev = 1'b0;
      end else begin
         tick = v && !m_vs_prev;
         rise = s && !m_st_prev;
         nxt  = m_phase;
         if (m_phase == 0 && rise)      nxt = 1;
         else if (m_phase == 1 && a)    nxt = 2;
         else if (m_phase == 1 && b)    nxt = 3;
         else if (m_phase >= 2 && tick && (m_n + 1 >= HOLD)) nxt = 0;
         if (tick) m_sel = 2'(m_phase);
         m_grst = (m_phase == 0) && rise;
         m_en   = (m_phase == 1);
         if (nxt != m_phase) m_n = 0;
         else if (m_phase >= 2 && tick) m_n++;
         m_phase = nxt;
         m_blink = (m_phase >= 2) ? (((m_n / BLINK) % 2) == 0) : 1'b0;
         m_vs_prev = v;
         m_st_prev = s;
      end
   endtask

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic step(input bit r, input bit s, input bit a, input bit b, input bit v);
      rst = r; start_btn = s; p1_win = a; p2_win = b; vsync = v;
      @(posedge clk);
      model_update(r, s, a, b, v);
      #1;
      chk("screen_sel", screen_sel, m_sel);
      chk("game_en", {1'b0, game_en}, {1'b0, m_en});
      chk("game_rst", {1'b0, game_rst}, {1'b0, m_grst});
      chk("blink_on", {1'b0, blink_on}, {1'b0, m_blink});
      chk("state", state_dbg, 2'(m_phase));
      @(negedge clk);
   endtask

   // One frame: two low cycles then two high cycles; blink_b is blink_on during the tick cycle.
   task automatic frame(input bit s, output bit blink_b);
      step(0, s, 0, 0, 0);
      step(0, s, 0, 0, 0);
      blink_b = blink_on;
      step(0, s, 0, 0, 1);
      step(0, s, 0, 0, 1);
   endtask

   typedef struct {
      bit r, s, a, b, v;
      logic [1:0] sel;
      bit en, grst, blink;
   } vec_t;

   vec_t vecs[13];

   initial begin
      bit bl;
      bit bseq[4];
      int gcount;
      int vcnt;
      bit s_lvl;

      //          r  s  a  b  v   sel  en grst bl
      vecs[0]  = '{1, 0, 0, 0, 1, 2'd0, 0, 0, 0};
      vecs[1]  = '{1, 0, 0, 0, 1, 2'd0, 0, 0, 0};
      vecs[2]  = '{0, 0, 0, 0, 1, 2'd0, 0, 0, 0};
      vecs[3]  = '{0, 0, 0, 0, 1, 2'd0, 0, 0, 0};
      vecs[4]  = '{0, 0, 0, 0, 0, 2'd0, 0, 0, 0};
      vecs[5]  = '{0, 1, 0, 0, 0, 2'd0, 0, 1, 0};
      vecs[6]  = '{0, 1, 0, 0, 0, 2'd0, 1, 0, 0};
      vecs[7]  = '{0, 1, 0, 0, 1, 2'd1, 1, 0, 0};
      vecs[8]  = '{0, 0, 0, 0, 1, 2'd1, 1, 0, 0};
      vecs[9]  = '{0, 0, 1, 1, 0, 2'd1, 1, 0, 1};
      vecs[10] = '{0, 0, 0, 0, 0, 2'd1, 0, 0, 1};
      vecs[11] = '{0, 0, 0, 0, 1, 2'd2, 0, 0, 1};
      vecs[12] = '{0, 0, 0, 0, 0, 2'd2, 0, 0, 1};

      for (int i = 0; i < 13; i++) begin
         step(vecs[i].r, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].v);
         chk($sformatf("vec%0d_sel", i), screen_sel, vecs[i].sel);
         chk($sformatf("vec%0d_en", i), {1'b0, game_en}, {1'b0, vecs[i].en});
         chk($sformatf("vec%0d_grst", i), {1'b0, game_rst}, {1'b0, vecs[i].grst});
         chk($sformatf("vec%0d_blink", i), {1'b0, blink_on}, {1'b0, vecs[i].blink});
      end

      // Randomized run against the model.
      vcnt = 0;
      s_lvl = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(14, 0) == 0) s_lvl = ~s_lvl;
         step(($urandom_range(399, 0) == 0), s_lvl,
              ($urandom_range(19, 0) == 0), ($urandom_range(19, 0) == 0), (vcnt >= 3));
         vcnt = (vcnt == 5) ? 0 : vcnt + 1;
      end

      // Winner-2 screen: blink pattern per tick and return to menu.
      step(1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      frame(0, bl);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      frame(0, bl);
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) frame(0, bseq[i]);
      chk("win2_blink_t1", {1'b0, bseq[0]}, 2'd1);
      chk("win2_blink_t2", {1'b0, bseq[1]}, 2'd1);
      chk("win2_blink_t3", {1'b0, bseq[2]}, 2'd0);
      chk("win2_blink_t4", {1'b0, bseq[3]}, 2'd0);
      chk("win2_exit_state", state_dbg, 2'd0);
      chk("win2_exit_sel_held", screen_sel, 2'd3);
      frame(0, bl);
      chk("win2_menu_sel", screen_sel, 2'd0);

      // Start held across the return to the menu does not restart play.
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      for (int i = 0; i < 6; i++) frame(1, bl);
      chk("held_start_state", state_dbg, 2'd0);
      chk("held_start_en", {1'b0, game_en}, 2'd0);
      step(0, 0, 0, 0, 0);
      gcount = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, 0, 0);
         gcount += int'(game_rst);
      end
      chk("repress_grst_count", 2'(gcount), 2'd1);
      chk("repress_state", state_dbg, 2'd1);

      // Reset mid winner-1 screen drops everything.
      step(0, 1, 1, 0, 0);
      frame(1, bl);
      frame(1, bl);
      chk("win1_pre_rst_state", state_dbg, 2'd2);
      chk("win1_pre_rst_blink", {1'b0, blink_on}, 2'd0);
      step(1, 0, 0, 0, 0);
      chk("rst_sel", screen_sel, 2'd0);
      chk("rst_en", {1'b0, game_en}, 2'd0);
      chk("rst_grst", {1'b0, game_rst}, 2'd0);
      chk("rst_blink", {1'b0, blink_on}, 2'd0);
      chk("rst_state", state_dbg, 2'd0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 1);
      step(0, 0, 0, 1, 0);
      chk("ignored_win_state", state_dbg, 2'd0);
      step(0, 1, 0, 0, 0);
      chk("post_rst_start_state", state_dbg, 2'd1);
      chk("post_rst_start_grst", {1'b0, game_rst}, 2'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/game_screen_ctrl.md
Name: game_screen_ctrl

Overview:
- Top-level screen sequencer for the VGA game.
- Tracks game phase (menu, play, player-1 won, player-2 won) from start-button and win events.
- Drives the select of the screen mux, which chooses between the background/menu, game and winner-overlay draw chains.
- Screen changes take effect only at frame boundaries (vsync rising edge) to prevent tearing. Winner screens are held for a fixed frame count, blink at a fixed rate, then return to the menu.

Parameters:
HOLD_FRAMES, 300, frames a winner screen is held before returning to menu (5 s at 60 Hz); legal range 1..2^CNT_W-1, value 0 treated as 1
BLINK_FRAMES, 30, frames per blink half-period on winner screens; legal range 1..2^CNT_W-1
CNT_W, 10, width of frame and blink counters

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
start_btn  in  1  start button, already synchronised/debounced level
p1_win  in  1  one-cycle pulse from game logic: player 1 won
p2_win  in  1  one-cycle pulse from game logic: player 2 won
vsync  in  1  vsync from VGA timing chain
screen_sel  out  2  mux select: 0 menu, 1 game, 2 player-1 won, 3 player-2 won
game_en  out  1  high while game logic may run
game_rst  out  1  one-cycle pulse clearing game logic at start of play
blink_on  out  1  winner-overlay visible phase; 0 outside winner screens

Behaviour:
- Clock and reset: reset rst, synchronous, active-high; clock clk. All outputs registered.
- Reset values: screen_sel=0, game_en=0, game_rst=0, blink_on=0, state=IDLE, counters=0. The vsync history register resets to 1, so no frame tick occurs if vsync is high at reset release.
- Edge detection:
  - frame_tick = vsync & ~vsync_q.
  - start_rise = start_btn & ~start_q.
  - Both are combinational from registered history.
- FSM states:
  - IDLE -> PLAY on start_rise.
  - PLAY -> WIN1 on p1_win.
  - PLAY -> WIN2 on p2_win (p1_win only if both in the same cycle; p1 has priority).
  - WIN1/WIN2 -> IDLE on a frame_tick when frame_cnt == HOLD_FRAMES-1.
- Ignored inputs:
  - Win pulses in IDLE/WIN are ignored.
  - start_rise in PLAY/WIN is ignored.
  - A start_btn held across the return to IDLE does not restart play; a new rising edge is required.
- State register latency: state updates on the clock edge after the triggering input cycle.
- game_rst: pulses high for exactly one cycle, the cycle after the IDLE->PLAY transition edge.
- game_en: registered (state==PLAY), so it is low from the cycle after leaving PLAY.
- Frame-synchronised screen_sel:
  - screen_sel loads the encoding of the current state only on a frame_tick cycle, visible the following cycle; otherwise it holds.
  - If the state changes twice within one frame, only the state present at the tick is shown.
- frame_cnt:
  - Cleared on any state transition.
  - In WIN states, increments on frame_tick.
  - Saturates at 2^CNT_W-1 and never wraps.
- blink_cnt / blink_on:
  - On entry to WIN1/WIN2: blink_cnt=0, blink_on=1.
  - On each frame_tick in WIN: if blink_cnt==BLINK_FRAMES-1, then blink_on toggles and blink_cnt=0; else blink_cnt increments.
  - Outside WIN states: blink_on=0.
- Simultaneous events: a frame_tick in the same cycle as a transition counts toward the new state's counters from zero only (the transition clears; no increment that cycle).
- Reset mid-operation: any state returns to IDLE next cycle with all outputs at reset values; a pending game_rst pulse is dropped.

Test Plan:
(Bench uses HOLD_FRAMES=4, BLINK_FRAMES=2, short vsync period.)
- Reset with vsync held high, release -> no frame_tick, screen_sel=0, game_en=0 for the first 3 frames without stimulus.
- start_btn rises mid-frame in IDLE -> game_rst high exactly 1 cycle, game_en=1 from next cycle, screen_sel stays 0 until the next vsync rise, then 1.
- In PLAY, p1_win and p2_win pulse in the same cycle -> WIN1, game_en=0 next cycle, screen_sel=2 after the next vsync rise.
- In WIN2 -> blink_on sequence per frame tick: 1,1,0,0 (toggle every 2 ticks); after the 4th frame_tick the state is IDLE, and screen_sel becomes 0 at the following tick.
- start_btn held high from PLAY through the return to IDLE -> stays IDLE. Release then press -> PLAY with a single game_rst pulse.
- rst asserted for 1 cycle while in WIN1 with blink_on=0 and frame_cnt=2 -> next cycle all outputs 0, state IDLE, p1_win pulses ignored until start.
